// File: rtl/sync_pulse_tx_if.sv
// sync_pulse_tx_if
//   Groups the request/configuration inputs and the pulse/status outputs of the
//   sync-link transmitter into one bundle.
//
//   Inputs to the transmitter (driven by the controller side):
//     i_start       level-sampled burst request
//     i_stop        graceful-stop request
//     i_period      pulse period in clock cycles
//     i_width       high time in clock cycles
//     i_num_pulses  pulses per burst, 0 = continuous
//   Outputs from the transmitter:
//     o_sync        registered sync pin
//     o_tick        one-cycle strobe on each rising edge of o_sync
//     o_busy        burst in progress
//     o_done        one-cycle strobe when a burst ends
//     o_pulse_cnt   pulses emitted in the current or last burst
interface sync_pulse_tx_if #(
  parameter int CNT_W = 32,
  parameter int NUM_W = 16
);

  logic             i_start;
  logic             i_stop;
  logic [CNT_W-1:0] i_period;
  logic [CNT_W-1:0] i_width;
  logic [NUM_W-1:0] i_num_pulses;

  logic             o_sync;
  logic             o_tick;
  logic             o_busy;
  logic             o_done;
  logic [NUM_W-1:0] o_pulse_cnt;

  modport master (
    output i_start,
    output i_stop,
    output i_period,
    output i_width,
    output i_num_pulses,
    input  o_sync,
    input  o_tick,
    input  o_busy,
    input  o_done,
    input  o_pulse_cnt
  );

  modport slave (
    input  i_start,
    input  i_stop,
    input  i_period,
    input  i_width,
    input  i_num_pulses,
    output o_sync,
    output o_tick,
    output o_busy,
    output o_done,
    output o_pulse_cnt
  );

endinterface

// File: rtl/sync_pulse_tx.sv
// sync_pulse_tx
//   Transmit end of the board-to-board sync link. Emits a programmable train
//   of sync pulses on a GPIO pin, either as a finite burst or continuously,
//   with a graceful stop that always completes the current period.
//
//   Ports:
//     i_clk    system clock
//     i_rset   synchronous reset, active-high
//     bus      sync_pulse_tx_if.slave (request/config in, pulse/status out)
//
//   state | meaning
//   ------+-----------------------------------------------------------------
//   IDLE  | no burst; waits for i_start, o_pulse_cnt holds last burst's count
//   HIGH  | o_sync high, r_timer counts down the remaining high cycles
//   LOW   | o_sync low, r_timer counts down the remaining low cycles; at the
//         | end either the next pulse starts or the burst finishes
module sync_pulse_tx #(
  parameter int CNT_W = 32,
  parameter int NUM_W = 16
) (
  input logic           i_clk,
  input logic           i_rset,
  sync_pulse_tx_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] r_per;
  logic [CNT_W-1:0] r_wid;
  logic [NUM_W-1:0] r_num;
  logic [NUM_W-1:0] r_cnt;
  logic             r_stop_pending;
  logic             r_sync;
  logic             r_tick;
  logic             r_busy;
  logic             r_done;

  logic [CNT_W-1:0] w_p_eff;
  logic [CNT_W-1:0] w_w_eff;
  logic [CNT_W-1:0] w_low_load;
  logic             w_last;
  logic             w_stop_req;

  // Effective timing from the raw inputs: the period is at least 2 so that a
  // pulse always has at least one high and one low cycle; the width is then
  // forced into [1, P-1].
  always_comb begin
    w_p_eff = (bus.i_period < CNT_W'(2)) ? CNT_W'(2) : bus.i_period;
    if (bus.i_width == '0) begin
      w_w_eff = CNT_W'(1);
    end else if (bus.i_width >= w_p_eff) begin
      w_w_eff = w_p_eff - CNT_W'(1);
    end else begin
      w_w_eff = bus.i_width;
    end
  end

  // Timers hold "cycles remaining after this one", so a phase of length L is
  // loaded with L-1. r_per > r_wid always holds, so this cannot underflow.
  assign w_low_load = r_per - r_wid - CNT_W'(1);

  assign w_last = (r_num != '0) && (r_cnt == r_num);

  // A stop seen on the final LOW cycle still ends this period rather than
  // letting one more pulse out.
  assign w_stop_req = r_stop_pending | bus.i_stop;

  always_ff @(posedge i_clk) begin
    if (i_rset) begin
      r_state        <= ST_IDLE;
      r_timer        <= '0;
      r_per          <= '0;
      r_wid          <= '0;
      r_num          <= '0;
      r_cnt          <= '0;
      r_stop_pending <= 1'b0;
      r_sync         <= 1'b0;
      r_tick         <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_done <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (bus.i_start) begin
            r_per          <= w_p_eff;
            r_wid          <= w_w_eff;
            r_num          <= bus.i_num_pulses;
            r_timer        <= w_w_eff - CNT_W'(1);
            r_cnt          <= NUM_W'(1);
            // START+STOP together yields exactly one pulse.
            r_stop_pending <= bus.i_stop;
            r_sync         <= 1'b1;
            r_tick         <= 1'b1;
            r_busy         <= 1'b1;
            r_state        <= ST_HIGH;
          end
        end

        ST_HIGH: begin
          if (bus.i_stop) begin
            r_stop_pending <= 1'b1;
          end
          if (r_timer == '0) begin
            r_sync  <= 1'b0;
            r_timer <= w_low_load;
            r_state <= ST_LOW;
          end else begin
            r_timer <= r_timer - CNT_W'(1);
          end
        end

        ST_LOW: begin
          if (bus.i_stop) begin
            r_stop_pending <= 1'b1;
          end
          if (r_timer == '0) begin
            if (w_stop_req || w_last) begin
              r_stop_pending <= 1'b0;
              r_busy         <= 1'b0;
              r_done         <= 1'b1;
              r_state        <= ST_IDLE;
            end else begin
              // Counter wraps freely; in continuous mode it never ends a burst.
              r_cnt   <= r_cnt + NUM_W'(1);
              r_sync  <= 1'b1;
              r_tick  <= 1'b1;
              r_timer <= r_wid - CNT_W'(1);
              r_state <= ST_HIGH;
            end
          end else begin
            r_timer <= r_timer - CNT_W'(1);
          end
        end

        default: begin
          r_sync  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.o_sync      = r_sync;
  assign bus.o_tick      = r_tick;
  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;
  assign bus.o_pulse_cnt = r_cnt;

endmodule

// File: tb/tb_sync_pulse_tx.sv
module tb_sync_pulse_tx;

  localparam int CNT_W = 32;
  localparam int NUM_W = 4;   // narrow so the wrap of the pulse counter is reachable

  logic clk = 1'b0;
  logic rset;
  always #5 clk = ~clk;

  sync_pulse_tx_if #(.CNT_W(CNT_W), .NUM_W(NUM_W)) bus ();

  sync_pulse_tx #(.CNT_W(CNT_W), .NUM_W(NUM_W)) dut (
    .i_clk  (clk),
    .i_rset (rset),
    .bus    (bus)
  );

  // kind 0 = tick, 1 = done
  typedef struct packed {
    logic [1:0]       kind;
    int               cyc;
    logic [NUM_W-1:0] cnt;
  } evt_t;

  evt_t exp_q[$];
  evt_t obs_q[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;
  int   t0     = 0;
  logic sync_at [0:8191];
  logic busy_at [0:8191];

  always @(posedge clk) cyc++;

  // Observation side: log what the DUT produced, cycle-stamped.
  always @(negedge clk) begin
    sync_at[cyc[12:0]] = bus.o_sync;
    busy_at[cyc[12:0]] = bus.o_busy;
    if (bus.o_tick === 1'b1) obs_q.push_back(evt_t'{kind: 2'd0, cyc: cyc, cnt: bus.o_pulse_cnt});
    if (bus.o_done === 1'b1) obs_q.push_back(evt_t'{kind: 2'd1, cyc: cyc, cnt: bus.o_pulse_cnt});
  end

  task automatic exp_tick(input int rel, input int n);
    exp_q.push_back(evt_t'{kind: 2'd0, cyc: t0 + rel, cnt: NUM_W'(n)});
  endtask

  task automatic exp_done(input int rel, input int n);
    exp_q.push_back(evt_t'{kind: 2'd1, cyc: t0 + rel, cnt: NUM_W'(n)});
  endtask

  // Start a burst: START sampled at the next edge (relative cycle 0);
  // outputs after that edge are relative cycle 1.
  task automatic go(input int p, input int w, input int n, input logic st, input int hold);
    @(negedge clk);
    exp_q.delete();
    obs_q.delete();
    bus.i_period     = CNT_W'(p);
    bus.i_width      = CNT_W'(w);
    bus.i_num_pulses = NUM_W'(n);
    bus.i_start      = 1'b1;
    bus.i_stop       = st;
    t0 = cyc;
    repeat (hold) @(negedge clk);
    bus.i_start = 1'b0;
    bus.i_stop  = 1'b0;
  endtask

  task automatic run_to(input int rel);
    while (cyc < t0 + rel) @(negedge clk);
  endtask

  task automatic test_reset;
    rset = 1'b1;
    bus.i_start = 1'b0; bus.i_stop = 1'b0;
    bus.i_period = '0; bus.i_width = '0; bus.i_num_pulses = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.o_sync, bus.o_tick, bus.o_busy, bus.o_done, bus.o_pulse_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got sync=%b tick=%b busy=%b done=%b cnt=%0d want all 0",
               bus.o_sync, bus.o_tick, bus.o_busy, bus.o_done, bus.o_pulse_cnt);
    end
    rset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    evt_t e, o;
    logic exp_s, exp_b;
    go(10, 3, 4, 1'b0, 1);
    exp_tick(1, 1); exp_tick(11, 2); exp_tick(21, 3); exp_tick(31, 4); exp_done(41, 4);
    run_to(46);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL basic_event missing want kind=%0d cyc=%0d cnt=%0d", e.kind, e.cyc - t0, e.cnt);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL basic_event got kind=%0d cyc=%0d cnt=%0d want kind=%0d cyc=%0d cnt=%0d",
                   o.kind, o.cyc - t0, o.cnt, e.kind, e.cyc - t0, e.cnt);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL basic_extra got %0d extra events want 0", obs_q.size()); end
    for (int r = 1; r <= 45; r++) begin
      exp_s = (r <= 40) && (((r - 1) % 10) < 3);
      exp_b = (r <= 40);
      checks++;
      if (sync_at[(t0 + r) % 8192] !== exp_s || busy_at[(t0 + r) % 8192] !== exp_b) begin
        errors++;
        $display("FAIL basic_wave cyc=%0d got sync=%b busy=%b want sync=%b busy=%b",
                 r, sync_at[(t0 + r) % 8192], busy_at[(t0 + r) % 8192], exp_s, exp_b);
      end
    end
    checks++;
    if (bus.o_pulse_cnt !== NUM_W'(4)) begin
      errors++; $display("FAIL basic_cnt_hold got %0d want 4", bus.o_pulse_cnt);
    end
  endtask

  task automatic test_clamp;
    evt_t e, o;
    logic exp_s;
    // P=0 -> 2, W=0 -> 1
    go(0, 0, 2, 1'b0, 1);
    exp_tick(1, 1); exp_tick(3, 2); exp_done(5, 2);
    run_to(8);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL clampA_event missing want kind=%0d cyc=%0d", e.kind, e.cyc - t0);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL clampA_event got kind=%0d cyc=%0d cnt=%0d want kind=%0d cyc=%0d cnt=%0d",
                   o.kind, o.cyc - t0, o.cnt, e.kind, e.cyc - t0, e.cnt);
        end
      end
    end
    for (int r = 1; r <= 6; r++) begin
      exp_s = (r == 1) || (r == 3);
      checks++;
      if (sync_at[(t0 + r) % 8192] !== exp_s) begin
        errors++; $display("FAIL clampA_sync cyc=%0d got %b want %b", r, sync_at[(t0 + r) % 8192], exp_s);
      end
    end
    // W=9 >= P=5 -> W=4
    go(5, 9, 1, 1'b0, 1);
    exp_tick(1, 1); exp_done(6, 1);
    run_to(9);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL clampB_event missing want kind=%0d cyc=%0d", e.kind, e.cyc - t0);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL clampB_event got kind=%0d cyc=%0d cnt=%0d want kind=%0d cyc=%0d cnt=%0d",
                   o.kind, o.cyc - t0, o.cnt, e.kind, e.cyc - t0, e.cnt);
        end
      end
    end
    for (int r = 1; r <= 6; r++) begin
      exp_s = (r <= 4);
      checks++;
      if (sync_at[(t0 + r) % 8192] !== exp_s) begin
        errors++; $display("FAIL clampB_sync cyc=%0d got %b want %b", r, sync_at[(t0 + r) % 8192], exp_s);
      end
    end
  endtask

  task automatic test_stop;
    evt_t e, o;
    go(8, 2, 0, 1'b0, 1);
    exp_tick(1, 1); exp_tick(9, 2); exp_tick(17, 3); exp_done(25, 3);
    run_to(20);
    bus.i_stop = 1'b1;
    @(negedge clk);
    bus.i_stop = 1'b0;
    run_to(40);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL stop_event missing want kind=%0d cyc=%0d", e.kind, e.cyc - t0);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL stop_event got kind=%0d cyc=%0d cnt=%0d want kind=%0d cyc=%0d cnt=%0d",
                   o.kind, o.cyc - t0, o.cnt, e.kind, e.cyc - t0, e.cnt);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL stop_extra got %0d extra events want 0", obs_q.size()); end
    checks++;
    if (sync_at[(t0 + 18) % 8192] !== 1'b1 || sync_at[(t0 + 19) % 8192] !== 1'b0) begin
      errors++; $display("FAIL stop_third_pulse got %b%b want 10", sync_at[(t0 + 18) % 8192], sync_at[(t0 + 19) % 8192]);
    end
  endtask

  task automatic test_start_stop_and_busy;
    evt_t e, o;
    go(6, 2, 5, 1'b1, 1);
    exp_tick(1, 1); exp_done(7, 1);
    run_to(12);
    go(10, 3, 2, 1'b0, 1);
    exp_tick(1, 1); exp_tick(11, 2); exp_done(21, 2);
    run_to(5);
    bus.i_period = CNT_W'(3); bus.i_width = CNT_W'(1); bus.i_num_pulses = NUM_W'(7);
    bus.i_start = 1'b1;
    @(negedge clk);
    bus.i_start = 1'b0;
    run_to(26);
    // first burst's events were cleared by the second go(); recheck it separately
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL busy_start_event missing want kind=%0d cyc=%0d", e.kind, e.cyc - t0);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL busy_start_event got kind=%0d cyc=%0d cnt=%0d want kind=%0d cyc=%0d cnt=%0d",
                   o.kind, o.cyc - t0, o.cnt, e.kind, e.cyc - t0, e.cnt);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL busy_start_extra got %0d extra events want 0", obs_q.size()); end
  endtask

  task automatic test_start_stop_single;
    evt_t e, o;
    go(6, 2, 5, 1'b1, 1);
    exp_tick(1, 1); exp_done(7, 1);
    run_to(14);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL start_stop_event missing want kind=%0d cyc=%0d", e.kind, e.cyc - t0);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL start_stop_event got kind=%0d cyc=%0d cnt=%0d want kind=%0d cyc=%0d cnt=%0d",
                   o.kind, o.cyc - t0, o.cnt, e.kind, e.cyc - t0, e.cnt);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL start_stop_extra got %0d extra events want 0", obs_q.size()); end
  endtask

  task automatic test_reset_mid_high;
    go(20, 5, 3, 1'b0, 1);
    run_to(2);
    rset = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.o_sync, bus.o_busy, bus.o_tick, bus.o_done, bus.o_pulse_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_mid got sync=%b busy=%b tick=%b done=%b cnt=%0d want all 0",
               bus.o_sync, bus.o_busy, bus.o_tick, bus.o_done, bus.o_pulse_cnt);
    end
    rset = 1'b0;
    run_to(25);
    // only the first tick may have been seen; no DONE and no further pulses
    checks++;
    if (obs_q.size() != 1 || obs_q[0].kind !== 2'd0 || obs_q[0].cyc != t0 + 1) begin
      errors++; $display("FAIL reset_mid_events got %0d events want 1 tick at cycle 1", obs_q.size());
    end
    checks++;
    if (bus.o_sync !== 1'b0 || bus.o_busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid_idle got sync=%b busy=%b want 0 0", bus.o_sync, bus.o_busy);
    end
  endtask

  task automatic test_back_to_back;
    evt_t e, o;
    go(4, 1, 1, 1'b0, 6);
    exp_tick(1, 1); exp_done(5, 1); exp_tick(6, 1); exp_done(10, 1);
    run_to(16);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL b2b_event missing want kind=%0d cyc=%0d", e.kind, e.cyc - t0);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL b2b_event got kind=%0d cyc=%0d cnt=%0d want kind=%0d cyc=%0d cnt=%0d",
                   o.kind, o.cyc - t0, o.cnt, e.kind, e.cyc - t0, e.cnt);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL b2b_extra got %0d extra events want 0", obs_q.size()); end
    checks++;
    if (busy_at[(t0 + 4) % 8192] !== 1'b1 || busy_at[(t0 + 5) % 8192] !== 1'b0 || busy_at[(t0 + 6) % 8192] !== 1'b1) begin
      errors++;
      $display("FAIL b2b_idle_gap got busy=%b%b%b want 101",
               busy_at[(t0 + 4) % 8192], busy_at[(t0 + 5) % 8192], busy_at[(t0 + 6) % 8192]);
    end
  endtask

  task automatic test_wrap;
    evt_t e, o;
    go(2, 1, 0, 1'b0, 1);
    for (int k = 0; k < 20; k++) exp_tick(1 + 2 * k, (k + 1) % 16);
    exp_done(41, 20 % 16);
    run_to(39);
    bus.i_stop = 1'b1;
    @(negedge clk);
    bus.i_stop = 1'b0;
    run_to(46);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin
        errors++; $display("FAIL wrap_event missing want kind=%0d cyc=%0d", e.kind, e.cyc - t0);
      end else begin
        o = obs_q.pop_front();
        if (o !== e) begin
          errors++;
          $display("FAIL wrap_event got kind=%0d cyc=%0d cnt=%0d want kind=%0d cyc=%0d cnt=%0d",
                   o.kind, o.cyc - t0, o.cnt, e.kind, e.cyc - t0, e.cnt);
        end
      end
    end
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL wrap_extra got %0d extra events want 0", obs_q.size()); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_clamp();
    test_stop();
    test_start_stop_single();
    test_start_stop_and_busy();
    test_reset_mid_high();
    test_back_to_back();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_pulse_tx.md
Name: sync_pulse_tx

Overview:
- Transmit end of the board-to-board sync link.
- Generates a programmable sync pulse train on a GPIO pin for the receiving board's sync state machine and counter to capture and time.
- Supports finite bursts or continuous output, with a graceful stop and status/handshake outputs for LEDs and the HEX readout path.

Parameters:
- CNT_W, 32, width of the period/width counters and PERIOD/WIDTH inputs.
- NUM_W, 16, width of the pulse-count request and PULSE_CNT output.

Ports:
- CLK  in  1  system clock (50 MHz in the top level).
- RSET  in  1  synchronous reset, active-high.
- START  in  1  level-sampled request: begins a burst when idle.
- STOP  in  1  request graceful stop at the end of the current period.
- PERIOD  in  CNT_W  pulse period in CLK cycles; latched at START.
- WIDTH  in  CNT_W  high time in CLK cycles; latched at START.
- NUM_PULSES  in  NUM_W  pulses per burst; 0 means continuous; latched at START.
- SYNC_O  out  1  registered sync output to GPIO.
- TICK  out  1  one-cycle strobe on the cycle SYNC_O rises.
- BUSY  out  1  high from the first pulse cycle until return to IDLE.
- DONE  out  1  one-cycle strobe when a burst ends.
- PULSE_CNT  out  NUM_W  pulses emitted in the current or last burst; wraps at 2^NUM_W.

Behaviour:
- Reset:
  - Applies on any RSET=1 clock edge, mid-burst included.
  - Next cycle: state IDLE; SYNC_O, TICK, BUSY, DONE = 0; PULSE_CNT = 0; internal counters and stop_pending = 0.
- Latched values at START (effective values):
  - P = max(PERIOD, 2).
  - W = WIDTH clamped to the range [1, P-1].
  - N = NUM_PULSES.
- States: IDLE, HIGH, LOW. All outputs are registered.
- IDLE:
  - If START=1 at edge n: latch P/W/N, clear PULSE_CNT, go to HIGH.
  - At edge n+1 output: SYNC_O=1, TICK=1, BUSY=1, PULSE_CNT=1.
  - Start latency is exactly 1 cycle.
- HIGH:
  - SYNC_O=1 for exactly W cycles, then LOW.
- LOW:
  - SYNC_O=0 for exactly P-W cycles.
  - At the end of LOW, return to IDLE if any of the following hold: stop_pending; N!=0 and PULSE_CNT==N; RSET.
  - Otherwise go to HIGH with TICK=1 and PULSE_CNT+1.
  - Rising edges are therefore exactly P cycles apart.
- End of burst:
  - On the cycle the state enters IDLE: DONE=1 for 1 cycle, BUSY=0, SYNC_O=0.
  - PULSE_CNT holds its final value until the next START.
- STOP:
  - When BUSY, sets stop_pending. The current pulse and period complete fully; no truncated pulse is ever emitted.
  - STOP in IDLE with START=0 is ignored.
  - STOP and START in the same IDLE cycle: the burst starts, stop_pending is set, exactly one pulse is emitted, then DONE.
- START while BUSY: ignored. Latched P/W/N do not change mid-burst.
- START held high at the DONE cycle: a new burst begins on the following edge (IDLE lasts at least 1 cycle).
- Continuous mode (N=0): runs until STOP or RSET. PULSE_CNT wraps modulo 2^NUM_W without affecting operation.
- Counter arithmetic: the cycle counter is CNT_W wide and reloaded at each state change. No overflow is possible because P ≤ 2^CNT_W-1.

Test Plan:
- Basic burst:
  - Stimulus: PERIOD=10, WIDTH=3, NUM_PULSES=4, START pulse at cycle 0.
  - Response: SYNC_O high on cycles 1-3, 11-13, 21-23, 31-33; TICK on cycles 1, 11, 21, 31; DONE at cycle 41; PULSE_CNT=4; BUSY cycles 1-40.
- Clamping:
  - Case PERIOD=0, WIDTH=0, N=2: rises at cycles 1 and 3, each high for 1 cycle.
  - Case PERIOD=5, WIDTH=9, N=1: SYNC_O high for cycles 1-4, low at cycle 5, DONE at cycle 6.
- Continuous with STOP:
  - Stimulus: N=0, P=8, W=2; STOP pulsed at cycle 20 (mid third period).
  - Response: third pulse completes; DONE at cycle 25; PULSE_CNT=3; no further TICK.
- Simultaneous START+STOP in IDLE, and START while BUSY:
  - START+STOP together: exactly 1 pulse, then DONE.
  - Re-asserting START with PERIOD=3 mid-burst: timing stays at the latched P.
- Reset mid-HIGH:
  - Stimulus: RSET=1 at cycle 2 of a W=5 pulse.
  - Response: next cycle SYNC_O=0, BUSY=0, PULSE_CNT=0, and no DONE strobe.
- Back-to-back bursts:
  - Stimulus: START held high, N=1, P=4, W=1.
  - Response: DONE at cycle 5, next TICK at cycle 6; exactly one IDLE cycle between bursts.
